// File: rtl/fp_mult_arbiter_if.sv
// Bundle between the requester array / response consumer / shared multiplier
// and the fp_mult_arbiter controller.
interface fp_mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic [31:0]           mult_a;
  logic [31:0]           mult_b;
  logic [31:0]           mult_result;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mult_result,
    output req_ready, resp_valid, resp_id, resp_result, mult_a, mult_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mult_result,
    input  req_ready, resp_valid, resp_id, resp_result, mult_a, mult_b, busy
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// Round-robin sharing of one pipelined FP multiplier among NUM_REQ requesters,
// with an ID tag pipeline and a credit-protected response FIFO.
module fp_mult_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 1,
  parameter int RESP_DEPTH   = 4
) (
  input logic              clk,
  input logic              rst,
  fp_mult_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (RESP_DEPTH > 2) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int NSTG  = MULT_LATENCY + 1;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic               hs;
  logic               can_issue;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  int                 inflight;

  logic [NSTG-1:0]    stg_vld;
  logic [ID_W-1:0]    stg_id [NSTG];

  logic [ID_W-1:0]    fifo_id   [RESP_DEPTH];
  logic [31:0]        fifo_data [RESP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = 0;
    for (int s = 0; s < NSTG; s++) inflight += int'(stg_vld[s]);
  end

  // Credits are taken from registered counts only, so a same-cycle pop never frees a slot early.
  assign can_issue = (inflight + int'(fifo_count)) < RESP_DEPTH;

  // Scan from ptr+NUM_REQ down to ptr+1 so the lowest offset above ptr wins.
  always_comb begin
    cand      = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    grant     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        grant_id  = cand;
        grant_any = 1'b1;
      end
    end
    if (grant_any && can_issue && !rst) grant[grant_id] = 1'b1;
  end

  assign hs            = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= ID_W'(NUM_REQ - 1);
      bus.mult_a <= '0;
      bus.mult_b <= '0;
      stg_vld    <= '0;
      for (int s = 0; s < NSTG; s++) stg_id[s] <= '0;
    end else begin
      stg_vld[0] <= hs;
      stg_id[0]  <= grant_id;
      for (int s = 1; s < NSTG; s++) begin
        stg_vld[s] <= stg_vld[s-1];
        stg_id[s]  <= stg_id[s-1];
      end
      if (hs) begin
        ptr        <= grant_id;
        bus.mult_a <= sel_a;
        bus.mult_b <= sel_b;
      end
    end
  end

  assign push = stg_vld[NSTG-1];
  assign pop  = bus.resp_valid & bus.resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_id[wr_ptr]   <= stg_id[NSTG-1];
      fifo_data[wr_ptr] <= bus.mult_result;
    end
  end

  assign bus.resp_valid  = (fifo_count != '0);
  assign bus.resp_id     = bus.resp_valid ? fifo_id[rd_ptr]   : '0;
  assign bus.resp_result = bus.resp_valid ? fifo_data[rd_ptr] : '0;
  assign bus.busy        = !rst && ((inflight != 0) || (fifo_count != '0));

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with a truncating single-precision
// multiplier model of latency 1.
module tb_fp_mult_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int MULT_LATENCY = 1;
  localparam int RESP_DEPTH   = 4;

  localparam logic [31:0] P314 = 32'h4048F5C3;
  localparam logic [31:0] N314 = 32'hC048F5C3;
  localparam logic [31:0] P5   = 32'h40A00000;
  localparam logic [31:0] N5   = 32'hC0A00000;
  localparam logic [31:0] R_P  = 32'h417B3333;
  localparam logic [31:0] R_N  = 32'hC17B3333;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] THR  = 32'h40400000;
  localparam logic [31:0] SIX  = 32'h40C00000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mult_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  fp_mult_arbiter #(
    .NUM_REQ(NUM_REQ), .MULT_LATENCY(MULT_LATENCY), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Normal operands only; mantissa product truncated.
  function automatic logic [31:0] fmul_trunc(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:0] == '0 || b[30:0] == '0) return {s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  logic [31:0] mult_q;
  always_ff @(posedge clk) mult_q <= fmul_trunc(bus.mult_a, bus.mult_b);
  assign bus.mult_result = mult_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  int          gnt_q[$];
  int          gnt_cyc_q[$];
  int          resp_id_q[$];
  logic [31:0] resp_res_q[$];
  int          pop_cyc_q[$];
  int          cyc = 0;
  bit          auto_drop = 0;
  int          outstanding = 0;
  int          max_out = 0;

  function automatic int q_get(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  function automatic logic [31:0] r_get(input logic [31:0] q[$], input int k);
    if (k < q.size()) return q[k];
    return 32'hDEADBEEF;
  endfunction

  task automatic clear_mon();
    gnt_q.delete();
    gnt_cyc_q.delete();
    resp_id_q.delete();
    resp_res_q.delete();
    pop_cyc_q.delete();
  endtask

  // Sample at negedge, let the edge happen, then drop granted one-shot requests.
  task automatic cycle();
    logic [NUM_REQ-1:0] hs;
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        gnt_q.push_back(i);
        gnt_cyc_q.push_back(cyc);
        outstanding++;
      end
    end
    if (bus.resp_valid && bus.resp_ready) begin
      resp_id_q.push_back(int'(bus.resp_id));
      resp_res_q.push_back(bus.resp_result);
      pop_cyc_q.push_back(cyc);
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop) bus.req_valid = bus.req_valid & ~hs;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic sign_ops();
    set_op(0, P314, P5);
    set_op(1, N314, P5);
    set_op(2, P314, N5);
    set_op(3, N314, N5);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    auto_drop      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    outstanding = 0;
    clear_mon();
  endtask

  logic [31:0] exp_sign [4];
  int          c0;

  initial begin
    exp_sign[0] = R_P;
    exp_sign[1] = R_N;
    exp_sign[2] = R_N;
    exp_sign[3] = R_P;

    // Reset state, with all requesters valid to show grants are held off.
    rst            = 1'b1;
    bus.req_valid  = '1;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_eq("rst_resp_id", 32'(bus.resp_id), 32'h0);
    check_eq("rst_resp_result", bus.resp_result, 32'h0);
    check_eq("rst_mult_a", bus.mult_a, 32'h0);
    check_eq("rst_mult_b", bus.mult_b, 32'h0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = '0;

    // 1: single op and latency
    set_op(0, P314, P5);
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    @(negedge clk);
    check_eq("t1_busy_T", 32'(bus.busy), 32'h1);
    check_eq("t1_valid_T", 32'(bus.resp_valid), 32'h0);
    @(negedge clk);
    check_eq("t1_valid_T1", 32'(bus.resp_valid), 32'h0);
    @(negedge clk);
    check_eq("t1_valid_T2", 32'(bus.resp_valid), 32'h1);
    check_eq("t1_id", 32'(bus.resp_id), 32'h0);
    check_eq("t1_result", bus.resp_result, R_P);
    @(negedge clk);
    check_eq("t1_valid_after_pop", 32'(bus.resp_valid), 32'h0);
    check_eq("t1_busy_after_pop", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;

    // 2: sign combinations, one op per requester
    do_reset();
    sign_ops();
    bus.resp_ready = 1'b1;
    auto_drop      = 1'b1;
    bus.req_valid  = 4'b1111;
    repeat (8) cycle();
    check_eq("t2_n_grants", 32'(gnt_q.size()), 32'd4);
    check_eq("t2_n_resp", 32'(resp_id_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2_grant%0d", k), 32'(q_get(gnt_q, k)), 32'(k));
      check_eq($sformatf("t2_resp_id%0d", k), 32'(q_get(resp_id_q, k)), 32'(k));
      check_eq($sformatf("t2_result%0d", k), r_get(resp_res_q, k), exp_sign[k]);
    end

    // 3: round robin, all requesters held valid for 8 cycles
    do_reset();
    sign_ops();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b1111;
    repeat (8) cycle();
    bus.req_valid = '0;
    repeat (4) cycle();
    check_eq("t3_n_grants", 32'(gnt_q.size()), 32'd8);
    check_eq("t3_n_resp", 32'(resp_id_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("t3_grant%0d", k), 32'(q_get(gnt_q, k)), 32'(k % 4));
      check_eq($sformatf("t3_gap%0d", k), 32'(q_get(gnt_cyc_q, k) - q_get(gnt_cyc_q, 0)), 32'(k));
      check_eq($sformatf("t3_resp_id%0d", k), 32'(q_get(resp_id_q, k)), 32'(k % 4));
      check_eq($sformatf("t3_result%0d", k), r_get(resp_res_q, k), exp_sign[k % 4]);
    end

    // 4: backpressure with requester 2 streaming
    do_reset();
    set_op(2, TWO, THR);
    bus.req_valid = 4'b0100;
    repeat (8) cycle();
    check_eq("t4_n_grants", 32'(gnt_q.size()), 32'd4);
    check_eq("t4_grant_id", 32'(q_get(gnt_q, 3)), 32'd2);
    @(negedge clk);
    check_eq("t4_req_ready_full", 32'(bus.req_ready), 32'h0);
    check_eq("t4_resp_valid", 32'(bus.resp_valid), 32'h1);
    check_eq("t4_resp_id", 32'(bus.resp_id), 32'h2);
    check_eq("t4_resp_result", bus.resp_result, SIX);
    check_eq("t4_busy", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #1;
    clear_mon();
    auto_drop      = 1'b1;
    bus.resp_ready = 1'b1;
    repeat (8) cycle();
    check_eq("t4_n_pops", 32'(resp_id_q.size()), 32'd5);
    check_eq("t4_n_resume", 32'(gnt_q.size()), 32'd1);
    check_eq("t4_resume_delay", 32'(q_get(gnt_cyc_q, 0) - q_get(pop_cyc_q, 0)), 32'd1);
    check_eq("t4_last_id", 32'(q_get(resp_id_q, 4)), 32'd2);
    check_eq("t4_last_result", r_get(resp_res_q, 4), SIX);

    // 5: reset with 2 ops in flight and 1 in the FIFO
    do_reset();
    set_op(0, TWO, THR);
    bus.req_valid = 4'b0001;
    repeat (3) cycle();
    check_eq("t5_n_grants", 32'(gnt_q.size()), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_busy_in_rst", 32'(bus.busy), 32'h0);
    check_eq("t5_ready_in_rst", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    outstanding    = 0;
    clear_mon();
    repeat (5) cycle();
    check_eq("t5_no_resp", 32'(resp_id_q.size()), 32'd0);
    @(negedge clk);
    check_eq("t5_busy_after", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    sign_ops();
    auto_drop     = 1'b1;
    bus.req_valid = 4'b1111;
    cycle();
    check_eq("t5_first_winner", 32'(q_get(gnt_q, 0)), 32'd0);
    bus.req_valid = '0;
    repeat (4) cycle();

    // 6: fairness between requesters 1 and 3
    do_reset();
    sign_ops();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b0010;
    repeat (3) cycle();
    check_eq("t6_solo_grants", 32'(gnt_q.size()), 32'd3);
    clear_mon();
    c0            = cyc;
    bus.req_valid = 4'b1010;
    repeat (6) cycle();
    bus.req_valid = '0;
    repeat (4) cycle();
    check_eq("t6_latency_ok", 32'((q_get(gnt_cyc_q, 0) - c0) <= 1), 32'h1);
    for (int k = 0; k < 6; k++)
      check_eq($sformatf("t6_grant%0d", k), 32'(q_get(gnt_q, k)), (k % 2 == 0) ? 32'd3 : 32'd1);

    check_eq("no_overflow", 32'(max_out <= RESP_DEPTH), 32'h1);
    check_eq("drained", 32'(outstanding), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one pipelined floating_point_multiplier (IEEE-754 single precision, ports clk/a/b/result) between NUM_REQ requesters, such as neuron update units in the SNN core.
- Round-robin arbitration issues at most one operand pair per cycle. Each operation's requester ID travels alongside it through the multiplier pipeline.
- Products go into a response FIFO. Credit-based issue control ensures a product is never dropped.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- MULT_LATENCY, 1, clk edges from operands stable at multiplier inputs until mult_result is valid (>=0).
- RESP_DEPTH, 4, response FIFO entries; must be >= MULT_LATENCY+3 for full throughput.
- ID_W (localparam), max(1, clog2(NUM_REQ)), requester ID width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant (combinational)
- req_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*NUM_REQ  operand B, same packing
- resp_valid  out  1  FIFO head valid
- resp_ready  in  1  consumer accepts head
- resp_id  out  ID_W  requester index of head product
- resp_result  out  32  head product
- mult_a  out  32  registered operand A to multiplier
- mult_b  out  32  registered operand B to multiplier
- mult_result  in  32  multiplier product
- busy  out  1  any operation in flight or FIFO non-empty

Behaviour:
- Reset (rst=1 at a rising edge), resulting state:
  - mult_a = mult_b = 0.
  - Tag pipeline cleared (all stage valids 0).
  - FIFO emptied; resp_valid = 0, resp_id = 0, resp_result = 0.
  - RR pointer set to NUM_REQ-1, so requester 0 has top priority.
  - req_ready = 0 and busy = 0 while rst=1.
- Reset mid-operation: in-flight products are discarded and never enter the FIFO. FIFO contents are lost.
- Issue condition: can_issue = (inflight + fifo_count) < RESP_DEPTH.
  - Both counts are registered state; a pop in the current cycle does not credit until the next cycle.
- Arbitration (combinational):
  - If can_issue and any req_valid, grant exactly one requester.
  - The grantee is the first asserted req_valid searching from (ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[i] = grant[i]. All other req_ready are 0.
- Requester protocol:
  - Hold req_valid and operands stable until req_ready is seen.
  - req_valid must not depend on req_ready.
- Handshake at edge T (req_valid[i] & req_ready[i]):
  - mult_a, mult_b <= operands of requester i.
  - ptr <= i.
  - Tag pipeline stage 0 <= {valid=1, id=i}.
  - Without a handshake, stage 0 valid <= 0; mult_a/mult_b hold their values.
- Tag pipeline:
  - MULT_LATENCY+1 stages, shifting every cycle.
  - inflight = count of valid stages.
  - The last stage is valid during the cycle after edge T+MULT_LATENCY. At edge T+MULT_LATENCY+1, {id, mult_result} is pushed into the FIFO.
- Response FIFO:
  - First-word fall-through; resp_valid = (fifo_count != 0).
  - Pop on resp_valid & resp_ready.
  - Simultaneous push and pop: count unchanged, pointers wrap mod RESP_DEPTH.
  - Push to a full FIFO cannot occur by construction. The bench asserts this as a check.
- Latency: handshake edge T -> resp_valid high after edge T+MULT_LATENCY+1.
- Throughput: 1 op/cycle sustained when resp_ready=1 and RESP_DEPTH >= MULT_LATENCY+3.
- Ordering: responses return in issue order; no reordering.
- Arithmetic: operands and products are passed through unmodified; the controller performs no FP computation.
- busy = (inflight != 0) | (fifo_count != 0).

Test Plan (defaults; bench multiplier instance with MULT_LATENCY=1):
1. Single op: requester 0 sends a=0x4048F5C3 (3.14), b=0x40A00000 (5.0); handshake at edge T -> resp_valid after edge T+2 with resp_result=0x417B3333, resp_id=0; busy returns to 0 after the pop.
2. Signs: requesters 0-3 send (±3.14)×(±5.0) -> results 0x417B3333, 0xC17B3333, 0xC17B3333, 0x417B3333 with ids 0,1,2,3 in that order.
3. Round-robin: all four req_valid held high for 8 cycles with resp_ready=1 -> grants 0,1,2,3,0,1,2,3, one per cycle; no gaps; responses in the same id order.
4. Backpressure: resp_ready=0, requester 2 streams -> exactly 4 handshakes, then req_ready stays 0 and 4 entries are held. Raise resp_ready -> 4 pops, and issue resumes the cycle after the first pop.
5. Reset mid-operation: assert rst for one cycle with 2 ops in flight and 1 in the FIFO -> no response ever appears; busy=0, req_ready=0 during reset. Requester 0 wins first after reset when all requesters are valid.
6. Fairness: requester 1 continuously valid, requester 3 asserts valid later -> requester 3 is granted within 2 cycles, and grants then alternate 1,3,1,3.
